// File: rtl/gan_seq_ctrl.sv
// Transaction sequencer for the combinational GAN datapath: it accepts one request,
// drives the datapath from registers, waits a fixed settle window, captures the
// datapath outputs and holds them on a valid/ready response port until they are taken.
module gan_seq_ctrl #(
    parameter int unsigned WIDTH         = 32,
    parameter int unsigned SETTLE_CYCLES = 4,
    parameter int unsigned CNT_W         = 16
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 req_valid,
    output logic                 req_ready,
    input  logic                 req_choice,
    input  logic [WIDTH-1:0]     req_in_1,
    input  logic [WIDTH-1:0]     req_in_2,
    output logic                 dp_choice,
    output logic [WIDTH-1:0]     dp_in_1,
    output logic [WIDTH-1:0]     dp_in_2,
    input  logic [WIDTH-1:0]     dp_disc,
    input  logic [9*WIDTH-1:0]   dp_pixels,
    output logic                 rsp_valid,
    input  logic                 rsp_ready,
    output logic                 rsp_choice,
    output logic [WIDTH-1:0]     rsp_disc,
    output logic [9*WIDTH-1:0]   rsp_pixels,
    output logic                 busy,
    output logic [CNT_W-1:0]     txn_count
);

    localparam int unsigned PIX_W = 9 * WIDTH;
    localparam int unsigned SET_W = (SETTLE_CYCLES > 1) ? $clog2(SETTLE_CYCLES) : 1;
    localparam logic [SET_W-1:0] SET_LOAD = SET_W'(SETTLE_CYCLES - 1);

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_SETTLE = 2'd1,
        S_RESP   = 2'd2
    } state_t;

    state_t             state_q,      state_d;
    logic [SET_W-1:0]   cnt_q,        cnt_d;
    logic               dp_choice_q,  dp_choice_d;
    logic [WIDTH-1:0]   dp_in_1_q,    dp_in_1_d;
    logic [WIDTH-1:0]   dp_in_2_q,    dp_in_2_d;
    logic               rsp_valid_q,  rsp_valid_d;
    logic               rsp_choice_q, rsp_choice_d;
    logic [WIDTH-1:0]   rsp_disc_q,   rsp_disc_d;
    logic [PIX_W-1:0]   rsp_pixels_q, rsp_pixels_d;
    logic [CNT_W-1:0]   txn_count_q,  txn_count_d;
    logic               req_ready_q,  req_ready_d;
    logic               busy_q,       busy_d;

    // Next-state and register-update logic; every register holds unless its state acts on it.
    always_comb begin
        state_d      = state_q;
        cnt_d        = cnt_q;
        dp_choice_d  = dp_choice_q;
        dp_in_1_d    = dp_in_1_q;
        dp_in_2_d    = dp_in_2_q;
        rsp_valid_d  = rsp_valid_q;
        rsp_choice_d = rsp_choice_q;
        rsp_disc_d   = rsp_disc_q;
        rsp_pixels_d = rsp_pixels_q;
        txn_count_d  = txn_count_q;

        unique case (state_q)
            S_IDLE: begin
                if (req_valid) begin
                    dp_choice_d = req_choice;
                    dp_in_1_d   = req_in_1;
                    dp_in_2_d   = req_in_2;
                    cnt_d       = SET_LOAD;
                    state_d     = S_SETTLE;
                end
            end
            S_SETTLE: begin
                if (cnt_q == '0) begin
                    rsp_choice_d = dp_choice_q;
                    rsp_disc_d   = dp_disc;
                    rsp_pixels_d = dp_pixels;
                    rsp_valid_d  = 1'b1;
                    state_d      = S_RESP;
                end else begin
                    cnt_d = cnt_q - SET_W'(1);
                end
            end
            S_RESP: begin
                if (rsp_ready) begin
                    rsp_valid_d = 1'b0;
                    txn_count_d = txn_count_q + CNT_W'(1);
                    state_d     = S_IDLE;
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase

        // Status flags are registered from the next state so they line up with state_q.
        req_ready_d = (state_d == S_IDLE);
        busy_d      = (state_d != S_IDLE);
    end

    // State and data registers with synchronous reset; req_ready comes out of reset high.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= S_IDLE;
            cnt_q        <= '0;
            dp_choice_q  <= 1'b0;
            dp_in_1_q    <= '0;
            dp_in_2_q    <= '0;
            rsp_valid_q  <= 1'b0;
            rsp_choice_q <= 1'b0;
            rsp_disc_q   <= '0;
            rsp_pixels_q <= '0;
            txn_count_q  <= '0;
            req_ready_q  <= 1'b1;
            busy_q       <= 1'b0;
        end else begin
            state_q      <= state_d;
            cnt_q        <= cnt_d;
            dp_choice_q  <= dp_choice_d;
            dp_in_1_q    <= dp_in_1_d;
            dp_in_2_q    <= dp_in_2_d;
            rsp_valid_q  <= rsp_valid_d;
            rsp_choice_q <= rsp_choice_d;
            rsp_disc_q   <= rsp_disc_d;
            rsp_pixels_q <= rsp_pixels_d;
            txn_count_q  <= txn_count_d;
            req_ready_q  <= req_ready_d;
            busy_q       <= busy_d;
        end
    end

    assign req_ready  = req_ready_q;
    assign busy       = busy_q;
    assign dp_choice  = dp_choice_q;
    assign dp_in_1    = dp_in_1_q;
    assign dp_in_2    = dp_in_2_q;
    assign rsp_valid  = rsp_valid_q;
    assign rsp_choice = rsp_choice_q;
    assign rsp_disc   = rsp_disc_q;
    assign rsp_pixels = rsp_pixels_q;
    assign txn_count  = txn_count_q;

endmodule

// File: tb/tb_gan_seq_ctrl.sv
// Scoreboard bench for gan_seq_ctrl: a stand-in datapath whose outputs only become
// correct SETTLE-1 edges after its inputs change, a timestamp-based reference model,
// and a negedge monitor that checks every output against it.
module tb_gan_seq_ctrl;

    localparam int unsigned WIDTH = 32;
    localparam int unsigned S     = 4;
    localparam int unsigned CNT_W = 2;
    localparam int unsigned PIX_W = 9 * WIDTH;
    localparam logic [WIDTH-1:0] Q1 = 32'h0100_0000;
    localparam logic [WIDTH-1:0] Q0 = 32'h0000_0000;

    logic               clk = 1'b0;
    logic               rst = 1'b1;
    logic               req_valid = 1'b0;
    logic               req_ready;
    logic               req_choice = 1'b0;
    logic [WIDTH-1:0]   req_in_1 = '0;
    logic [WIDTH-1:0]   req_in_2 = '0;
    logic               dp_choice;
    logic [WIDTH-1:0]   dp_in_1;
    logic [WIDTH-1:0]   dp_in_2;
    logic [WIDTH-1:0]   dp_disc;
    logic [PIX_W-1:0]   dp_pixels;
    logic               rsp_valid;
    logic               rsp_ready = 1'b0;
    logic               rsp_choice;
    logic [WIDTH-1:0]   rsp_disc;
    logic [PIX_W-1:0]   rsp_pixels;
    logic               busy;
    logic [CNT_W-1:0]   txn_count;

    int unsigned n_checks = 0;
    int unsigned n_fail   = 0;
    int unsigned cyc      = 0;
    logic        rand_rdy = 1'b0;

    gan_seq_ctrl #(.WIDTH(WIDTH), .SETTLE_CYCLES(S), .CNT_W(CNT_W)) dut (
        .clk(clk), .rst(rst),
        .req_valid(req_valid), .req_ready(req_ready), .req_choice(req_choice),
        .req_in_1(req_in_1), .req_in_2(req_in_2),
        .dp_choice(dp_choice), .dp_in_1(dp_in_1), .dp_in_2(dp_in_2),
        .dp_disc(dp_disc), .dp_pixels(dp_pixels),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_choice(rsp_choice),
        .rsp_disc(rsp_disc), .rsp_pixels(rsp_pixels),
        .busy(busy), .txn_count(txn_count)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc++;

    // Golden datapath functions (arbitrary but input-sensitive stand-ins for top_level).
    function automatic logic [WIDTH-1:0] gold_disc(input logic c, input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b);
        return a ^ {b[WIDTH-4:0], b[WIDTH-1:WIDTH-3]} ^ (c ? 32'hA5A5_0F0F : 32'h0000_0000) ^ 32'h1234_5678;
    endfunction

    function automatic logic [PIX_W-1:0] gold_pix(input logic c, input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b);
        logic [PIX_W-1:0] p;
        p = '0;
        for (int k = 0; k < 9; k++)
            p[k*WIDTH +: WIDTH] = a + b * WIDTH'(k + 1) + (c ? (WIDTH'(k) << 24) : (32'h00FF_0000 ^ WIDTH'(k)));
        return p;
    endfunction

    // Stand-in datapath: outputs reach the golden value S-1 edges after dp_* change.
    logic [WIDTH-1:0] disc_pipe [S-1];
    logic [PIX_W-1:0] pix_pipe  [S-1];
    always @(posedge clk) begin
        disc_pipe[0] <= gold_disc(dp_choice, dp_in_1, dp_in_2);
        pix_pipe[0]  <= gold_pix(dp_choice, dp_in_1, dp_in_2);
        for (int i = 1; i < S - 1; i++) begin
            disc_pipe[i] <= disc_pipe[i-1];
            pix_pipe[i]  <= pix_pipe[i-1];
        end
    end
    assign dp_disc   = disc_pipe[S-2];
    assign dp_pixels = pix_pipe[S-2];

    task automatic check(input string name, input logic [PIX_W-1:0] act, input logic [PIX_W-1:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s at cycle %0d: got %0h expected %0h", name, cyc, act, exp);
        end
    endtask

    // Reference model state.
    typedef struct {
        logic             c;
        logic [WIDTH-1:0] d;
        logic [PIX_W-1:0] p;
    } exp_t;

    exp_t             sb_q[$];
    exp_t             m_last = '{c: 1'b0, d: '0, p: '0};
    logic             m_idle = 1'b1;
    logic             m_rv   = 1'b0;
    logic             m_dpc  = 1'b0;
    logic [WIDTH-1:0] m_dp1  = '0;
    logic [WIDTH-1:0] m_dp2  = '0;
    logic [CNT_W-1:0] m_cnt  = '0;
    int unsigned      capture_at = 0;
    logic             mon_en = 1'b0;

    // Monitor: check the state left by the last edge, then advance the model for the next edge.
    always @(negedge clk) begin
        if (mon_en) begin
            check("req_ready", PIX_W'(req_ready), PIX_W'(m_idle));
            check("busy", PIX_W'(busy), PIX_W'(!m_idle));
            check("rsp_valid", PIX_W'(rsp_valid), PIX_W'(m_rv));
            check("dp_choice", PIX_W'(dp_choice), PIX_W'(m_dpc));
            check("dp_in_1", PIX_W'(dp_in_1), PIX_W'(m_dp1));
            check("dp_in_2", PIX_W'(dp_in_2), PIX_W'(m_dp2));
            check("txn_count", PIX_W'(txn_count), PIX_W'(m_cnt));
            if (m_rv) begin
                if (sb_q.size() == 0) begin
                    check("scoreboard_nonempty", PIX_W'(0), PIX_W'(1));
                end else begin
                    check("rsp_choice", PIX_W'(rsp_choice), PIX_W'(sb_q[0].c));
                    check("rsp_disc", PIX_W'(rsp_disc), PIX_W'(sb_q[0].d));
                    check("rsp_pixels", rsp_pixels, sb_q[0].p);
                end
            end else begin
                check("rsp_choice_hold", PIX_W'(rsp_choice), PIX_W'(m_last.c));
                check("rsp_disc_hold", PIX_W'(rsp_disc), PIX_W'(m_last.d));
                check("rsp_pixels_hold", rsp_pixels, m_last.p);
            end
        end

        if (rst) begin
            sb_q.delete();
            m_last = '{c: 1'b0, d: '0, p: '0};
            m_idle = 1'b1;
            m_rv   = 1'b0;
            m_dpc  = 1'b0;
            m_dp1  = '0;
            m_dp2  = '0;
            m_cnt  = '0;
            mon_en = 1'b1;
        end else if (m_idle && req_valid) begin
            m_idle = 1'b0;
            m_dpc  = req_choice;
            m_dp1  = req_in_1;
            m_dp2  = req_in_2;
            sb_q.push_back('{c: req_choice, d: gold_disc(req_choice, req_in_1, req_in_2),
                             p: gold_pix(req_choice, req_in_1, req_in_2)});
            capture_at = cyc + 1 + S;
        end else if (!m_idle && !m_rv) begin
            if (cyc + 1 == capture_at) m_rv = 1'b1;
        end else if (m_rv && rsp_ready) begin
            m_last = sb_q.pop_front();
            m_rv   = 1'b0;
            m_idle = 1'b1;
            m_cnt  = m_cnt + CNT_W'(1);
        end
    end

    // Random consumer backpressure when enabled.
    always @(posedge clk) begin
        if (rand_rdy) begin
            #1;
            rsp_ready = ($urandom_range(0, 3) != 0);
        end
    end

    // Present a request and hold it until accepted; returns the accept edge number.
    task automatic send(input logic c, input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b,
                        output int unsigned acc);
        logic ok;
        ok = 1'b0;
        acc = 0;
        req_valid  = 1'b1;
        req_choice = c;
        req_in_1   = a;
        req_in_2   = b;
        for (int i = 0; i < 200 && !ok; i++) begin
            @(negedge clk);
            if (req_ready) ok = 1'b1;
        end
        if (ok) begin
            acc = cyc + 1;
            @(posedge clk);
            #1;
        end else begin
            n_checks++;
            n_fail++;
            $display("FAIL send_timeout at cycle %0d: got req_ready=0 expected 1 within 200 cycles", cyc);
        end
        req_valid = 1'b0;
    endtask

    task automatic wait_idle();
        logic ok;
        ok = 1'b0;
        for (int i = 0; i < 300 && !ok; i++) begin
            @(posedge clk);
            #1;
            if (sb_q.size() == 0 && m_idle) ok = 1'b1;
        end
        if (!ok) begin
            n_checks++;
            n_fail++;
            $display("FAIL idle_timeout at cycle %0d: got busy expected idle within 300 cycles", cyc);
        end
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog at cycle %0d: got running expected finished", cyc);
        $fatal(1, "watchdog");
    end

    initial begin
        int unsigned acc, prev;
        logic [WIDTH-1:0] va [2];
        logic [WIDTH-1:0] vb [2];
        logic ok;

        // Reset for three cycles.
        repeat (3) @(posedge clk);
        #1;
        rst = 1'b0;
        @(posedge clk);
        #1;

        // Single transaction with immediate consumer.
        rsp_ready = 1'b1;
        send(1'b0, Q0, Q1, acc);
        wait_idle();

        // Backpressure while extra requests are pulsed.
        rsp_ready = 1'b0;
        send(1'b1, Q1, 32'h0280_0000, acc);
        ok = 1'b0;
        for (int i = 0; i < 50 && !ok; i++) begin
            @(posedge clk);
            #1;
            if (m_rv) ok = 1'b1;
        end
        check("rsp_valid_rise_bound", PIX_W'(ok), PIX_W'(1));
        for (int i = 0; i < 10; i++) begin
            req_valid  = i[0];
            req_choice = $urandom_range(0, 1) == 1;
            req_in_1   = $urandom;
            req_in_2   = $urandom;
            @(posedge clk);
            #1;
        end
        req_valid = 1'b0;
        rsp_ready = 1'b1;
        wait_idle();

        // Back-to-back sweep; accepts must be S+2 edges apart.
        va[0] = Q0; vb[0] = Q1;
        va[1] = Q1; vb[1] = Q0;
        prev = 0;
        for (int k = 0; k < 4; k++) begin
            send(k[1], va[k%2], vb[k%2], acc);
            if (k > 0) check("accept_spacing", PIX_W'(acc - prev), PIX_W'(S + 2));
            prev = acc;
        end
        wait_idle();

        // Reset two cycles into the settle window.
        send(1'b1, 32'hDEAD_BEEF, 32'h0123_4567, acc);
        @(posedge clk);
        #1;
        rst = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
        repeat (S + 4) @(posedge clk);
        #1;

        // Random traffic with backpressure; counter wraps modulo 2^CNT_W.
        rand_rdy = 1'b1;
        for (int k = 0; k < 40; k++) begin
            repeat ($urandom_range(0, 3)) @(posedge clk);
            #1;
            case ($urandom_range(0, 2))
                0:       send($urandom_range(0, 1) == 1, Q1, Q0, acc);
                1:       send($urandom_range(0, 1) == 1, Q0, Q1, acc);
                default: send($urandom_range(0, 1) == 1, $urandom, $urandom, acc);
            endcase
        end
        wait_idle();
        rand_rdy = 1'b0;
        repeat (3) @(posedge clk);
        #1;

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
